// File: rtl/csr_file.sv
// csr_file: machine-mode CSR register file with trap updates and 64-bit cycle/instret counters
module csr_file #(
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
  parameter logic [31:0] MISA_VALUE  = 32'h4000_0100,
  parameter logic [31:0] HART_ID     = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        n_rst_i,
  input  logic [11:0] raddr_i,
  output logic [31:0] rdata_o,
  input  logic        we_i,
  input  logic [11:0] waddr_i,
  input  logic [31:0] wdata_i,
  input  logic        instret_i,
  input  logic        irq_external_i,
  input  logic        irq_timer_i,
  input  logic        irq_sw_i,
  input  logic        set_cause_i,
  input  logic        ie_type_i,
  input  logic [3:0]  trap_cause_i,
  input  logic        set_epc_i,
  input  logic [31:0] epc_i,
  input  logic        set_mtval_i,
  input  logic [31:0] mtval_i,
  input  logic        mstatus_ie_clear_i,
  input  logic        mstatus_ie_set_i,
  output logic        mstatus_ie_o,
  output logic        mie_external_o,
  output logic        mie_timer_o,
  output logic        mie_sw_o,
  output logic        mip_external_o,
  output logic        mip_timer_o,
  output logic        mip_sw_o,
  output logic [31:0] mtvec_o,
  output logic [31:0] epc_o
);
  logic        mie_b, mpie;
  logic [2:0]  mie_r, mip_r;
  logic [31:0] mtvec, mscratch, mepc, mcause, mtval;
  logic [63:0] mcycle, minstret;
  logic [31:0] mstatus_w, mie_w, mip_w;
  assign mstatus_w = {19'b0, 2'b11, 3'b0, mpie, 3'b0, mie_b, 3'b0};
  assign mie_w     = {20'b0, mie_r[2], 3'b0, mie_r[1], 3'b0, mie_r[0], 3'b0};
  assign mip_w     = {20'b0, mip_r[2], 3'b0, mip_r[1], 3'b0, mip_r[0], 3'b0};
  always_comb begin
    rdata_o = '0;
    case (raddr_i)
      12'h300: rdata_o = mstatus_w;
      12'h301: rdata_o = MISA_VALUE;
      12'h304: rdata_o = mie_w;
      12'h305: rdata_o = mtvec;
      12'h340: rdata_o = mscratch;
      12'h341: rdata_o = mepc;
      12'h342: rdata_o = mcause;
      12'h343: rdata_o = mtval;
      12'h344: rdata_o = mip_w;
      12'hB00: rdata_o = mcycle[31:0];
      12'hB80: rdata_o = mcycle[63:32];
      12'hB02: rdata_o = minstret[31:0];
      12'hB82: rdata_o = minstret[63:32];
      12'hF14: rdata_o = HART_ID;
      default: rdata_o = '0;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (n_rst_i) begin
      mie_b    <= 1'b0;
      mpie     <= 1'b0;
      mie_r    <= '0;
      mip_r    <= '0;
      mtvec    <= MTVEC_RESET;
      mscratch <= '0;
      mepc     <= '0;
      mcause   <= '0;
      mtval    <= '0;
      mcycle   <= '0;
      minstret <= '0;
    end else begin
      if (mstatus_ie_clear_i) begin
        mpie  <= mie_b;
        mie_b <= 1'b0;
      end else if (mstatus_ie_set_i) begin
        mie_b <= mpie;
        mpie  <= 1'b1;
      end else if (we_i && waddr_i == 12'h300) begin
        mie_b <= wdata_i[3];
        mpie  <= wdata_i[7];
      end
      if (we_i && waddr_i == 12'h304) mie_r <= {wdata_i[11], wdata_i[7], wdata_i[3]};
      if (we_i && waddr_i == 12'h305) mtvec <= wdata_i & ~32'd2;
      if (we_i && waddr_i == 12'h340) mscratch <= wdata_i;
      mip_r    <= {irq_external_i, irq_timer_i, irq_sw_i};
      mepc     <= set_epc_i ? epc_i & ~32'd3 : (we_i && waddr_i == 12'h341) ? wdata_i & ~32'd3 : mepc;
      mcause   <= set_cause_i ? {ie_type_i, 27'b0, trap_cause_i} : (we_i && waddr_i == 12'h342) ? wdata_i : mcause;
      mtval    <= set_mtval_i ? mtval_i : (we_i && waddr_i == 12'h343) ? wdata_i : mtval;
      mcycle   <= (we_i && waddr_i == 12'hB00) ? {mcycle[63:32], wdata_i} :
                  (we_i && waddr_i == 12'hB80) ? {wdata_i, mcycle[31:0]} : mcycle + 64'd1;
      minstret <= (we_i && waddr_i == 12'hB02) ? {minstret[63:32], wdata_i} :
                  (we_i && waddr_i == 12'hB82) ? {wdata_i, minstret[31:0]} : minstret + {63'd0, instret_i};
    end
  end
  assign mstatus_ie_o   = mie_b;
  assign mie_external_o = mie_r[2];
  assign mie_timer_o    = mie_r[1];
  assign mie_sw_o       = mie_r[0];
  assign mip_external_o = mip_r[2];
  assign mip_timer_o    = mip_r[1];
  assign mip_sw_o       = mip_r[0];
  assign mtvec_o        = mtvec;
  assign epc_o          = mepc;
endmodule

// File: tb/tb_csr_file.sv
// tb_csr_file: randomized scoreboard bench for csr_file against a behavioural CSR model
module tb_csr_file;
  localparam logic [31:0] MTVEC_RST = 32'h8000_0001;
  logic        clk_i = 1'b0;
  logic        n_rst_i, we_i, instret_i, irq_external_i, irq_timer_i, irq_sw_i;
  logic        set_cause_i, ie_type_i, set_epc_i, set_mtval_i, mstatus_ie_clear_i, mstatus_ie_set_i;
  logic [11:0] raddr_i, waddr_i;
  logic [31:0] rdata_o, wdata_i, epc_i, mtval_i, mtvec_o, epc_o;
  logic [3:0]  trap_cause_i;
  logic        mstatus_ie_o, mie_external_o, mie_timer_o, mie_sw_o, mip_external_o, mip_timer_o, mip_sw_o;
  logic [6:0]  flags;
  csr_file #(.MTVEC_RESET(MTVEC_RST)) dut (
    .clk_i(clk_i), .n_rst_i(n_rst_i), .raddr_i(raddr_i), .rdata_o(rdata_o),
    .we_i(we_i), .waddr_i(waddr_i), .wdata_i(wdata_i), .instret_i(instret_i),
    .irq_external_i(irq_external_i), .irq_timer_i(irq_timer_i), .irq_sw_i(irq_sw_i),
    .set_cause_i(set_cause_i), .ie_type_i(ie_type_i), .trap_cause_i(trap_cause_i),
    .set_epc_i(set_epc_i), .epc_i(epc_i), .set_mtval_i(set_mtval_i), .mtval_i(mtval_i),
    .mstatus_ie_clear_i(mstatus_ie_clear_i), .mstatus_ie_set_i(mstatus_ie_set_i),
    .mstatus_ie_o(mstatus_ie_o), .mie_external_o(mie_external_o), .mie_timer_o(mie_timer_o),
    .mie_sw_o(mie_sw_o), .mip_external_o(mip_external_o), .mip_timer_o(mip_timer_o),
    .mip_sw_o(mip_sw_o), .mtvec_o(mtvec_o), .epc_o(epc_o)
  );
  always #5 clk_i = ~clk_i;
  assign flags = {mstatus_ie_o, mie_external_o, mie_timer_o, mie_sw_o, mip_external_o, mip_timer_o, mip_sw_o};
  typedef struct { int kind; logic [31:0] exp; logic [11:0] addr; string name; } chk_t;
  chk_t q[$];
  int n_cmp = 0, n_bad = 0;
  logic        m_valid = 1'b0;
  logic        m_mie, m_mpie;
  logic [31:0] m_ie, m_ip, m_tvec, m_scratch, m_epc, m_cause, m_tval;
  logic [63:0] m_cyc, m_ins;
  logic [11:0] addrs [16] = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343,
                             12'h344, 12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hF14, 12'h7C0, 12'h000};
  function automatic logic [31:0] m_read(input logic [11:0] a);
    case (a)
      12'h300: return 32'h1800 + (m_mpie ? 32'h80 : 32'h0) + (m_mie ? 32'h8 : 32'h0);
      12'h301: return 32'h4000_0100;
      12'h304: return m_ie;
      12'h305: return m_tvec;
      12'h340: return m_scratch;
      12'h341: return m_epc;
      12'h342: return m_cause;
      12'h343: return m_tval;
      12'h344: return m_ip;
      12'hB00: return m_cyc[31:0];
      12'hB80: return m_cyc[63:32];
      12'hB02: return m_ins[31:0];
      12'hB82: return m_ins[63:32];
      default: return 32'h0;
    endcase
  endfunction
  function automatic logic [31:0] irq_word(input logic e, input logic t, input logic s);
    return (e ? 32'h800 : 32'h0) + (t ? 32'h80 : 32'h0) + (s ? 32'h8 : 32'h0);
  endfunction
  task automatic push(input int k, input logic [31:0] e, input string n);
    q.push_back('{k, e, raddr_i, n});
  endtask
  task automatic m_update();
    logic [11:0] wa;
    if (n_rst_i) begin
      {m_mie, m_mpie} = 2'b00;
      {m_ie, m_ip, m_scratch, m_epc, m_cause, m_tval} = '0;
      m_tvec = MTVEC_RST;
      m_cyc = 64'd0;
      m_ins = 64'd0;
      m_valid = 1'b1;
      return;
    end
    wa = we_i ? waddr_i : 12'hFFF;
    if (mstatus_ie_clear_i) begin
      m_mpie = m_mie;
      m_mie = 1'b0;
    end else if (mstatus_ie_set_i) begin
      m_mie = m_mpie;
      m_mpie = 1'b1;
    end else if (wa == 12'h300) begin
      m_mie = wdata_i[3];
      m_mpie = wdata_i[7];
    end
    if (wa == 12'h304) m_ie = wdata_i & 32'h888;
    if (wa == 12'h305) m_tvec = wdata_i & 32'hFFFF_FFFD;
    if (wa == 12'h340) m_scratch = wdata_i;
    if (set_epc_i) m_epc = epc_i & 32'hFFFF_FFFC;
    else if (wa == 12'h341) m_epc = wdata_i & 32'hFFFF_FFFC;
    if (set_cause_i) m_cause = (ie_type_i ? 32'h8000_0000 : 32'h0) + 32'(trap_cause_i);
    else if (wa == 12'h342) m_cause = wdata_i;
    if (set_mtval_i) m_tval = mtval_i;
    else if (wa == 12'h343) m_tval = wdata_i;
    m_ip = irq_word(irq_external_i, irq_timer_i, irq_sw_i);
    if (wa == 12'hB00) m_cyc[31:0] = wdata_i;
    else if (wa == 12'hB80) m_cyc[63:32] = wdata_i;
    else m_cyc = m_cyc + 64'd1;
    if (wa == 12'hB02) m_ins[31:0] = wdata_i;
    else if (wa == 12'hB82) m_ins[63:32] = wdata_i;
    else if (instret_i) m_ins = m_ins + 64'd1;
  endtask
  task automatic tick();
    if (m_valid) begin
      push(0, m_read(raddr_i), "rdata");
      push(1, {25'd0, m_mie, m_ie[11], m_ie[7], m_ie[3], m_ip[11], m_ip[7], m_ip[3]}, "flags");
      push(2, m_tvec, "mtvec_o");
      push(3, m_epc, "epc_o");
    end
    @(posedge clk_i);
    m_update();
    #1;
    {n_rst_i, we_i, set_cause_i, set_epc_i, set_mtval_i, mstatus_ie_clear_i, mstatus_ie_set_i, instret_i} = '0;
  endtask
  task automatic expect_rd(input logic [11:0] a, input logic [31:0] v, input string n);
    raddr_i = a;
    push(0, v, n);
    tick();
  endtask
  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    we_i = 1'b1;
    waddr_i = a;
    wdata_i = d;
    tick();
  endtask
  always @(negedge clk_i) begin
    while (q.size() > 0) begin
      chk_t c;
      logic [31:0] act;
      c = q.pop_front();
      act = c.kind == 0 ? rdata_o : c.kind == 1 ? {25'd0, flags} : c.kind == 2 ? mtvec_o :
            c.kind == 3 ? epc_o : c.kind == 4 ? {31'd0, mstatus_ie_o} : {31'd0, mip_timer_o};
      n_cmp++;
      if (act !== c.exp) begin
        n_bad++;
        $display("FAIL %s raddr=%h got=%h expected=%h t=%0t", c.name, c.addr, act, c.exp, $time);
      end
    end
  end
  initial begin
    {n_rst_i, we_i, instret_i, irq_external_i, irq_timer_i, irq_sw_i} = '0;
    {set_cause_i, ie_type_i, set_epc_i, set_mtval_i, mstatus_ie_clear_i, mstatus_ie_set_i} = '0;
    {raddr_i, waddr_i, wdata_i, epc_i, mtval_i, trap_cause_i} = '0;
    @(posedge clk_i);
    #1;
    n_rst_i = 1'b1;
    tick();
    push(1, 32'h0, "reset_flags");
    expect_rd(12'h305, MTVEC_RST, "reset_mtvec");
    expect_rd(12'h301, 32'h4000_0100, "misa");
    expect_rd(12'hF14, 32'h0, "mhartid");
    expect_rd(12'h300, 32'h0000_1800, "reset_mstatus");
    wr(12'h300, 32'h8);
    mstatus_ie_clear_i = 1'b1;
    tick();
    push(4, 32'h0, "trap_mie_o");
    expect_rd(12'h300, 32'h0000_1880, "trap_mstatus");
    mstatus_ie_set_i = 1'b1;
    tick();
    push(4, 32'h1, "mret_mie_o");
    expect_rd(12'h300, 32'h0000_1888, "mret_mstatus");
    {set_cause_i, ie_type_i, trap_cause_i, set_epc_i, epc_i} = {1'b1, 1'b1, 4'b0111, 1'b1, 32'h8000_0106};
    wr(12'h341, 32'h1234);
    expect_rd(12'h342, 32'h8000_0007, "trap_mcause");
    push(3, 32'h8000_0104, "trap_epc_o");
    expect_rd(12'h341, 32'h8000_0104, "trap_mepc");
    wr(12'h305, 32'h0000_0103);
    expect_rd(12'h305, 32'h0000_0101, "mtvec_warl");
    wr(12'h344, 32'hFFFF_FFFF);
    expect_rd(12'h344, 32'h0, "mip_ro");
    irq_timer_i = 1'b1;
    tick();
    push(5, 32'h1, "mip_timer_o");
    expect_rd(12'h344, 32'h80, "mip_timer");
    irq_timer_i = 1'b0;
    wr(12'hB00, 32'hFFFF_FFFE);
    wr(12'hB80, 32'h0);
    tick();
    tick();
    expect_rd(12'hB00, 32'h0, "mcycle_lo_wrap");
    expect_rd(12'hB80, 32'h1, "mcycle_hi_carry");
    for (int i = 0; i < 10; i++) begin
      instret_i = (i % 2 == 0);
      tick();
    end
    expect_rd(12'hB02, 32'd5, "minstret_5");
    wr(12'hB82, 32'hFFFF_FFFF);
    wr(12'hB02, 32'hFFFF_FFFF);
    instret_i = 1'b1;
    tick();
    expect_rd(12'hB82, 32'h0, "minstret_wrap_hi");
    expect_rd(12'hB02, 32'h0, "minstret_wrap_lo");
    {n_rst_i, set_cause_i, trap_cause_i} = {1'b1, 1'b1, 4'd3};
    wr(12'h340, 32'hDEAD_BEEF);
    expect_rd(12'hB00, 32'h0, "rst_mcycle");
    expect_rd(12'h342, 32'h0, "rst_mcause");
    expect_rd(12'h340, 32'h0, "rst_mscratch");
    expect_rd(12'h305, MTVEC_RST, "rst_mtvec");
    expect_rd(12'h300, 32'h0000_1800, "rst_mstatus");
    for (int i = 0; i < 3000; i++) begin
      n_rst_i = ($urandom_range(0, 199) == 0);
      we_i = ($urandom_range(0, 2) == 0);
      waddr_i = addrs[$urandom_range(0, 15)];
      wdata_i = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF - 32'($urandom_range(0, 3)) : $urandom;
      instret_i = 1'($urandom_range(0, 1));
      {irq_external_i, irq_timer_i, irq_sw_i} = 3'($urandom_range(0, 7));
      set_cause_i = ($urandom_range(0, 7) == 0);
      set_epc_i = ($urandom_range(0, 7) == 0);
      set_mtval_i = ($urandom_range(0, 7) == 0);
      mstatus_ie_clear_i = ($urandom_range(0, 7) == 0);
      mstatus_ie_set_i = ($urandom_range(0, 7) == 0);
      ie_type_i = 1'($urandom_range(0, 1));
      trap_cause_i = 4'($urandom_range(0, 15));
      epc_i = $urandom;
      mtval_i = $urandom;
      raddr_i = addrs[$urandom_range(0, 15)];
      tick();
    end
    @(negedge clk_i);
    #1;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain got=%0d expected=0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/csr_file.md
Name: csr_file

Overview:
- Machine-mode CSR register file downstream of the trap/interrupt controller.
- Applies the controller's trap-entry/return updates (mcause, mepc, mtval, mstatus.MIE/MPIE) and software CSR writes from the writeback stage.
- Serves CSR reads to decode, and returns interrupt-enable/pending state, mtvec and mepc to the controller.
- Holds mcycle/minstret 64-bit counters.

Parameters:
MTVEC_RESET, 32'h0000_0000, reset value of mtvec
MISA_VALUE, 32'h4000_0100, read-only misa (RV32I)
HART_ID, 32'h0000_0000, read-only mhartid

Ports:
clk_i  in  1  clock
n_rst_i  in  1  synchronous reset, active-high
raddr_i  in  12  CSR read address
rdata_o  out  32  CSR read data (combinational)
we_i  in  1  software CSR write enable (writeback)
waddr_i  in  12  write address
wdata_i  in  32  write data (already read-modify-write resolved)
instret_i  in  1  one instruction retired this cycle
irq_external_i / irq_timer_i / irq_sw_i  in  1 each  raw interrupt lines
set_cause_i  in  1  load mcause
ie_type_i  in  1  1=interrupt, 0=exception
trap_cause_i  in  4  cause code
set_epc_i  in  1  load mepc
epc_i  in  32  trapping PC
set_mtval_i  in  1  load mtval
mtval_i  in  32  trap value
mstatus_ie_clear_i  in  1  trap entry
mstatus_ie_set_i  in  1  mret
mstatus_ie_o  out  1  mstatus.MIE
mie_external_o / mie_timer_o / mie_sw_o  out  1 each  mie.MEIE/MTIE/MSIE
mip_external_o / mip_timer_o / mip_sw_o  out  1 each  mip.MEIP/MTIP/MSIP
mtvec_o  out  32  mtvec
epc_o  out  32  mepc

Behaviour:
- Map: 0x300 mstatus, 0x301 misa (RO), 0x304 mie, 0x305 mtvec, 0x340 mscratch, 0x341 mepc, 0x342 mcause, 0x343 mtval, 0x344 mip (RO), 0xB00/0xB80 mcycle lo/hi, 0xB02/0xB82 minstret lo/hi, 0xF14 mhartid (RO).
- Unmapped read returns 0; writes to RO/unmapped addresses are ignored.
- Reset: all registers 0 except mtvec=MTVEC_RESET. All outputs reflect reset state in the next cycle (mstatus_ie_o=0, mie_*=0, mip_*=0, epc_o=0).
- mstatus read = {19'b0, 2'b11 (MPP), 3'b0, MPIE, 3'b0, MIE, 3'b0}. Only bits 7 and 3 are writable.
- mie/mip use bits 11/7/3 (external/timer/sw). Other bits read 0.
- mip bits are registered copies of irq_*_i: one-cycle latency, level-sensitive, software writes ignored.
- mtvec is WARL: bit1 forced 0 on write; mode 00 = direct, 01 = vectored.
- mepc bits[1:0] forced 0 on any load.
- mcause = {ie_type_i, 27'b0, trap_cause_i}.
- Trap entry (mstatus_ie_clear_i): MPIE<=MIE, MIE<=0.
- mret (mstatus_ie_set_i): MIE<=MPIE, MPIE<=1.
- If clear and set are asserted together, clear wins.
- All updates take effect at the clock edge, so reads see them the next cycle.
- Read-after-write: no bypass; a same-cycle read returns the old value.
- Priority per register: reset > trap/controller update > software write > counter increment.
  - Software write to mstatus in the same cycle as clear/set is dropped.
  - Software write to mepc/mcause/mtval in the same cycle as the matching set_* is dropped.
- mcycle increments every cycle after reset.
  - A software write to the lo or hi half replaces that half with wdata_i; that cycle's increment is suppressed.
  - The other half is held.
  - Wraps 2^64-1 -> 0.
- minstret: same rules, increments only when instret_i=1.
  - Carry from lo to hi occurs in the same cycle (64-bit add).
- Reset asserted mid-operation clears everything at that edge and overrides any concurrent set_*/we_i.

Test Plan:
- Reset, then read 0x305, 0x301, 0xF14, 0x300 -> MTVEC_RESET, 32'h4000_0100, 0, 32'h0000_1800.
- Write mstatus=0x8 (MIE=1), then pulse mstatus_ie_clear_i -> mstatus reads 0x1880, mstatus_ie_o=0. Then pulse mstatus_ie_set_i -> 0x1888, mstatus_ie_o=1.
- Trap entry with set_cause_i=1, ie_type_i=1, trap_cause_i=4'b0111, set_epc_i=1, epc_i=0x8000_0106; concurrent we_i to 0x341 with 0x1234 -> mcause=0x8000_0007, mepc=0x8000_0104 (write dropped).
- Write mtvec=0x0000_0103 -> reads 0x0000_0101. Write 0x344=0xFFFF_FFFF -> mip unchanged. Assert irq_timer_i -> mip_timer_o=1 one cycle later, mip reads 0x80.
- Write mcycle lo=0xFFFF_FFFE, hi=0 -> two cycles later mcycleh=1, mcycle lo=0. minstret with instret_i toggling 5 times -> minstret=5.
- Assert n_rst_i in the same cycle as set_cause_i and we_i -> all CSRs return reset values, and mcycle restarts from 0.
